// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - transmit word FIFO feeding the UART transmitter
// Buffers host words and launches them one at a time, holding each until the transmitter reports done.
module uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              flush_i,
  input  logic              clr_overflow_i,
  input  logic              tx_done_i,
  output logic [DATA_W-1:0] tx_data_o,
  output logic              start_tx_o,
  output logic              busy_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              overflow_o
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [0:0] IDLE      = 1'b0;
  localparam logic [0:0] WAIT_DONE = 1'b1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [0:0]        state;
  logic              push;
  logic              pop;
  logic              drop;

  assign full_o  = (count_o == CNT_W'(DEPTH));
  assign empty_o = (count_o == '0);

  // Flush outranks both the host write and the launch of a new character.
  assign push = wr_en_i && !full_o && !flush_i;
  assign pop  = (state == IDLE) && !empty_o && !flush_i;
  assign drop = wr_en_i && full_o && !flush_i;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
    end else if (flush_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_o <= count_o + CNT_W'(1);
        2'b01:   count_o <= count_o - CNT_W'(1);
        default: count_o <= count_o;
      endcase
    end
  end

  // A dropped write in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_o <= 1'b0;
    end else if (drop) begin
      overflow_o <= 1'b1;
    end else if (clr_overflow_i) begin
      overflow_o <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tx_data_o  <= '0;
      start_tx_o <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      start_tx_o <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            tx_data_o  <= mem[rd_ptr];
            start_tx_o <= 1'b1;
            busy_o     <= 1'b1;
            state      <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (tx_done_i) begin
            busy_o <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Transmit-side buffer between the APB register block and the UART transmitter.
- Queues 32-bit words written by the host.
- Launches one character at a time into the transmitter with a single-cycle start pulse, and holds the data word stable.
- Waits for the transmitter's done pulse before launching the next word.
- Reports fill level, full/empty and a sticky overflow flag back to the register block.

Parameters:
- DEPTH, 16, number of FIFO entries; power of two, at least 2.
- DATA_W, 32, width of each entry; matches the transmitter data input.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count (derived; do not override).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset.
- wr_en_i  input  1  host write strobe; pushes wr_data_i when not full.
- wr_data_i  input  DATA_W  word to enqueue.
- flush_i  input  1  discards all queued entries.
- clr_overflow_i  input  1  clears overflow_o.
- tx_done_i  input  1  one-cycle pulse from the transmitter when a character completes.
- tx_data_o  output  DATA_W  word presented to the transmitter.
- start_tx_o  output  1  one-cycle launch pulse to the transmitter.
- busy_o  output  1  a character is in flight (launched, done not yet seen).
- full_o  output  1  count_o == DEPTH.
- empty_o  output  1  count_o == 0.
- count_o  output  CNT_W  current number of queued entries (excludes the in-flight word).
- overflow_o  output  1  sticky; a write was dropped because the FIFO was full.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values:
  - tx_data_o = 0, start_tx_o = 0, busy_o = 0, count_o = 0, overflow_o = 0.
  - empty_o = 1, full_o = 0.
  - Read and write pointers = 0; FSM = IDLE.
  - Reset mid-transfer abandons the in-flight word. Queued data is lost. A later tx_done_i is ignored because the FSM is in IDLE.
- Storage:
  - Circular buffer with read and write pointers of $clog2(DEPTH) bits, wrapping DEPTH-1 -> 0.
  - count_o is tracked separately and is registered.
  - full_o and empty_o are derived combinationally from the registered count_o.
- Write:
  - Accepted when wr_en_i=1 and full_o=0. Data is stored at the write pointer, and the write pointer increments.
  - wr_en_i=1 while full_o=1: the data is dropped and overflow_o is set on the next edge. A pop in the same cycle does not rescue the write.
- FSM has two states, IDLE and WAIT_DONE.
  - IDLE with empty_o=0:
    - Pop the head entry: tx_data_o <= mem[rd_ptr], rd_ptr++, start_tx_o <= 1, busy_o <= 1.
    - Go to WAIT_DONE.
  - IDLE with empty_o=1: hold; start_tx_o = 0.
  - WAIT_DONE:
    - start_tx_o returns to 0 after exactly one cycle.
    - tx_data_o is held stable.
    - On tx_done_i=1: busy_o <= 0 and go to IDLE.
  - tx_done_i received in IDLE is ignored.
- Count arithmetic:
  - Push only: count +1. Pop only: count -1. Push and pop in the same cycle: count unchanged.
  - count_o never exceeds DEPTH and never goes below 0.
- Latency:
  - A write at edge N into an empty FIFO in IDLE gives empty_o=0 after N. start_tx_o is high in the cycle after edge N+1.
  - Back-to-back: tx_done_i sampled at edge M gives IDLE after M, and start_tx_o is high after M+1. There is a minimum of one idle cycle between characters.
- Flush:
  - flush_i=1 sets rd_ptr = wr_ptr = 0 and count_o = 0.
  - It does not abort the in-flight word: the FSM, busy_o and tx_data_o are unaffected.
  - A write in the same cycle as a flush is dropped and does not set overflow.
  - A flush in IDLE while non-empty has priority over the pop: no start_tx_o is issued.
- Overflow clear:
  - clr_overflow_i=1 clears overflow_o.
  - A simultaneous overflowing write wins, so overflow_o stays 1.

Test Plan:
- Reset, then write 0x000000A5 once. Required: count_o goes 0 -> 1 -> 0, start_tx_o is high for one cycle, tx_data_o=0x000000A5 and is held until tx_done_i, busy_o drops one cycle after tx_done_i.
- Write 3 words 0x11, 0x22, 0x33 back-to-back, with tx_done_i returned 10 cycles after each start. Required: three start pulses in the order 0x11, 0x22, 0x33; each start comes 2 cycles after the preceding tx_done_i; count_o reaches 2 maximum.
- With DEPTH=16 and tx_done_i withheld, write 18 words. Required:
  - One word in flight and 16 queued; full_o=1 and count_o=16.
  - The 18th write is dropped and overflow_o=1.
  - A clr_overflow_i pulse clears it.
  - Draining then delivers words 2..17 in order, exercising pointer wrap.
- Full FIFO, then apply wr_en_i together with a tx_done_i-induced pop in the same cycle. Required: the write is dropped, overflow_o=1, and count_o=15 afterwards.
- Queue 5 words with a transfer in flight, then assert flush_i. Required: count_o=0 and empty_o=1 next cycle; the in-flight tx_data_o is unchanged; after tx_done_i no further start_tx_o is issued.
- Assert rst while in WAIT_DONE with 4 queued words. Required: all outputs take their reset values on the next cycle; a subsequent tx_done_i produces no start_tx_o.
